// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, IR handoff to the decoder and
// PC-advance controls from the controller. master = fetch unit, slave = environment.
interface instr_fetch_unit_if;
   logic [31:0] PC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        loadPC;
   logic        PCSrc;
   logic [31:0] branch_offset;
   logic        fetch_err;

   modport master (
      output PC, imem_req, imem_addr, instr, instr_valid, fetch_err,
      input  imem_rdata, imem_valid, instr_ready, loadPC, PCSrc, branch_offset
   );

   modport slave (
      input  PC, imem_req, imem_addr, instr, instr_valid, fetch_err,
      output imem_rdata, imem_valid, instr_ready, loadPC, PCSrc, branch_offset
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, fetches into IR, hands IR to the decoder, advances PC on loadPC.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT timeout with a sticky fetch_err flag.
module instr_fetch_unit #(
   parameter logic [31:0] INITIAL_PC     = 32'h0040_0000,
   parameter int          TIMEOUT_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst,
   instr_fetch_unit_if.master bus
);
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_EXEC} state_t;

   state_t             state_q;
   logic [31:0]        pc_q;
   logic [31:0]        instr_q;
   logic               imem_req_q;
   logic               instr_valid_q;
   logic signed [31:0] br_off_s;
   logic [31:0]        br_target;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   // Branch targets are word aligned; low offset bits are simply dropped.
   assign br_off_s  = bus.branch_offset;
   assign br_target = (pc_q + br_off_s) & 32'hFFFF_FFFC;

`ifdef FETCH_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             fetch_err_q;

   assign bus.fetch_err = fetch_err_q;
`else
   assign bus.fetch_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_FETCH;
         pc_q          <= INITIAL_PC;
         instr_q       <= NOP_INSTR;
         imem_req_q    <= 1'b0;
         instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         tmo_cnt_q     <= '0;
         fetch_err_q   <= 1'b0;
`endif
      end else begin
         imem_req_q <= 1'b0;
         unique case (state_q)
            S_FETCH: begin
               imem_req_q <= 1'b1;
               state_q    <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
               tmo_cnt_q  <= '0;
`endif
            end
            S_WAIT: begin
               if (bus.imem_valid) begin
                  instr_q       <= bus.imem_rdata;
                  instr_valid_q <= 1'b1;
                  state_q       <= S_HOLD;
               end
`ifdef FETCH_TIMEOUT_EN
               // Give up on this response and re-request the same PC.
               else if (tmo_cnt_q == TMO_LAST) begin
                  fetch_err_q <= 1'b1;
                  state_q     <= S_FETCH;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
`endif
            end
            S_HOLD: begin
               if (bus.instr_ready) begin
                  instr_valid_q <= 1'b0;
                  state_q       <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (bus.loadPC) begin
                  pc_q    <= bus.PCSrc ? br_target : pc_q + 32'd4;
                  state_q <= S_FETCH;
               end
            end
            default: state_q <= S_FETCH;
         endcase
      end
   end

   assign bus.PC          = pc_q;
   assign bus.imem_addr   = pc_q;
   assign bus.imem_req    = imem_req_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: random memory latency and stray responses,
// random decoder/controller timing, PC checked against an arithmetic next-PC model.
module tb_instr_fetch_unit;
   localparam logic [31:0] INIT_PC = 32'h0040_0000;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.INITIAL_PC(INIT_PC), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_instr[$];
   logic [31:0] model_pc;
   logic [31:0] mon_addr;
   bit          exp_err       = 1'b0;
   bit          mon_en        = 1'b0;
   int          fixed_lat     = -1;
   bit          fixed_word_en = 1'b0;
   logic [31:0] fixed_word    = 32'h0;
   bit          hold_off      = 1'b0;
   bit          waiting       = 1'b0;
   int          wait_cnt      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_stop(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: DUT did not respond within the cycle budget", name);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "aborting");
   endtask

   // Next PC from the architectural rule: +4, or branch target rounded down to a word.
   function automatic logic [31:0] next_pc(input logic [31:0] pc, input bit src, input logic [31:0] off);
      logic [31:0] t;
      if (!src) return pc + 32'd4;
      t = pc + off;
      return t - (t % 32'd4);
   endfunction

   // ---------------- memory responder ----------------
   task automatic deliver();
      bus.imem_valid = 1'b1;
      if (fixed_word_en) begin
         bus.imem_rdata = fixed_word;
         fixed_word_en  = 1'b0;
      end else begin
         bus.imem_rdata = $urandom;
      end
      exp_instr.push_back(bus.imem_rdata);
      waiting = 1'b0;
   endtask

   initial begin : responder
      int lat;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'h0;
      forever begin
         @(posedge clk); #2;
         bus.imem_valid = 1'b0;
         bus.imem_rdata = $urandom;
         if (waiting) begin
            if (wait_cnt == 0) deliver();
            else wait_cnt--;
         end else if (bus.imem_req && !hold_off) begin
            lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            if (lat == 0) deliver();
            else begin
               waiting  = 1'b1;
               wait_cnt = lat - 1;
            end
         end else if (!hold_off && !bus.imem_req && $urandom_range(0, 3) == 0) begin
            bus.imem_valid = 1'b1;
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (bus.imem_req) begin
            if (exp_addr.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_req: got request at %h, expected none", bus.imem_addr);
            end else begin
               mon_addr = exp_addr.pop_front();
               check("imem_addr", bus.imem_addr, mon_addr);
               check("PC", bus.PC, mon_addr);
            end
            check("fetch_err", 32'(bus.fetch_err), 32'(exp_err));
         end
         if (bus.instr_valid) begin
            if (exp_instr.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_instr: got instr %h, expected no valid instruction", bus.instr);
            end else begin
               check("instr", bus.instr, exp_instr[0]);
               if (bus.instr_ready) void'(exp_instr.pop_front());
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_instr(input bit src, input logic [31:0] off, input bit hold);
      int guard;
      bit hs;
      guard = 0;
      hs    = 1'b0;
      if (hold) begin
         bus.instr_ready = 1'b0;
         bus.loadPC      = 1'b0;
         while (!bus.instr_valid && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (!bus.instr_valid) fail_stop("hold_wait_valid");
         repeat (5) begin
            @(posedge clk); #2;
            bus.loadPC        = 1'b1;
            bus.PCSrc         = 1'b1;
            bus.branch_offset = $urandom;
            @(negedge clk);
            check("hold_valid", 32'(bus.instr_valid), 32'd1);
            check("hold_pc", bus.PC, model_pc);
         end
         guard = 0;
      end
      do begin
         @(posedge clk); #2;
         bus.instr_ready   = ($urandom_range(0, 2) != 0);
         bus.loadPC        = ($urandom_range(0, 3) == 0);
         bus.PCSrc         = 1'($urandom);
         bus.branch_offset = $urandom;
         @(negedge clk);
         hs = bus.instr_valid && bus.instr_ready;
         guard++;
      end while (!hs && guard < 300);
      if (!hs) fail_stop("handoff");
      @(posedge clk); #2;
      bus.instr_ready = 1'b0;
      bus.loadPC      = 1'b0;
      repeat ($urandom_range(0, 2)) begin
         @(posedge clk); #2;
      end
      bus.loadPC        = 1'b1;
      bus.PCSrc         = src;
      bus.branch_offset = off;
      model_pc          = next_pc(model_pc, src, off);
      exp_addr.push_back(model_pc);
      @(posedge clk); #2;
      bus.loadPC = 1'b0;
   endtask

   task automatic reset_mid_fetch();
      int guard;
      guard     = 0;
      fixed_lat = 1;
      do begin
         @(negedge clk);
         guard++;
      end while (!bus.imem_req && guard < 50);
      if (!bus.imem_req) fail_stop("reset_wait_req");
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst_pc", bus.PC, INIT_PC);
      check("midrst_valid", 32'(bus.instr_valid), 32'd0);
      check("midrst_req", 32'(bus.imem_req), 32'd0);
      check("midrst_instr", bus.instr, NOP);
      @(posedge clk); #2;
      rst       = 1'b0;
      fixed_lat = -1;
      waiting   = 1'b0;
      exp_err   = 1'b0;
      exp_instr.delete();
      exp_addr.delete();
      model_pc = INIT_PC;
      exp_addr.push_back(INIT_PC);
   endtask

`ifdef FETCH_TIMEOUT_EN
   task automatic do_timeout();
      int guard;
      guard    = 0;
      hold_off = 1'b1;
      do begin
         @(negedge clk);
         guard++;
      end while (!bus.imem_req && guard < 50);
      if (!bus.imem_req) fail_stop("timeout_wait_req");
      exp_addr.push_back(model_pc);
      repeat (15) @(negedge clk);
      check("tmo_err_before", 32'(bus.fetch_err), 32'd0);
      check("tmo_no_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
      check("tmo_err_set", 32'(bus.fetch_err), 32'd1);
      exp_err  = 1'b1;
      hold_off = 1'b0;
      @(negedge clk);
      check("tmo_retry_req", 32'(bus.imem_req), 32'd1);
   endtask
`endif

   initial begin : driver
      bit          d_src[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] d_off[10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFF8,
                                 32'h0, 32'h0, 32'h6, 32'hFFBF_FFE8, 32'h0};
      bus.instr_ready   = 1'b0;
      bus.loadPC        = 1'b0;
      bus.PCSrc         = 1'b0;
      bus.branch_offset = 32'h0;
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      check("rst_pc", bus.PC, INIT_PC);
      check("rst_req", 32'(bus.imem_req), 32'd0);
      check("rst_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", bus.instr, NOP);
      check("rst_err", 32'(bus.fetch_err), 32'd0);

      fixed_lat     = 0;
      fixed_word    = 32'h0050_0093;
      fixed_word_en = 1'b1;
      model_pc      = INIT_PC;
      exp_addr.push_back(INIT_PC);
      mon_en = 1'b1;
      rst    = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("c1_req", 32'(bus.imem_req), 32'd1);
      check("c1_addr", bus.imem_addr, INIT_PC);
      @(negedge clk);
      check("c2_valid", 32'(bus.instr_valid), 32'd1);
      check("c2_instr", bus.instr, 32'h0050_0093);
      fixed_lat = -1;

      for (int i = 0; i < 10; i++) run_instr(d_src[i], d_off[i], i == 2);

      reset_mid_fetch();
`ifdef FETCH_TIMEOUT_EN
      do_timeout();
`endif

      for (int i = 0; i < 40; i++) begin
         logic [31:0] off;
         off = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
         run_instr(1'($urandom), off, $urandom_range(0, 7) == 0);
      end

      repeat (12) @(negedge clk);
      check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
